multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore control FSM directly upstream of the 16-bit multi-cycle DataPath: consumes opcode (IR[15:13]) and drives every
//  DataPath control input. Owns the fetch/decode/execute/memory/writeback sequence, including 1-cycle BRAM read wait states.
//  Also provides a run gate, halt/illegal status and a retired-instruction counter for bring-up and CPI measurement.
// PARAMETERS
//  COUNT_WIDTH   16  width of instr_count (wraps modulo 2^COUNT_WIDTH)
//  ILLEGAL_TRAP  1   1: illegal opcode parks FSM in ILLEGAL; 0: treated as NOP (-> FETCH), illegal flag still set
// PORTS
//  clock        in   1   single clock, all state updates on posedge
//  reset        in   1   asynchronous, active-high; forces IDLE, clears counter/flags immediately
//  run          in   1   start/continue gate, sampled only in IDLE and at instruction boundary (entry to FETCH)
//  opcode       in   3   from DataPath IR[15:13]; sampled only in DECODE and MEMADDR
//  ALUOp        out  2   00 add, 01 sub, 10 funct-decoded (R-type), 11 unused (never driven)
//  ALUSrcB      out  2   00 B, 01 const 2, 10 sign-ext offset, 11 branch offset
//  PCSource     out  2   00 ALU result, 01 ALUOut, 10 jump address
//  RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA   out 1 each
//  halted       out  1   sticky: HALT opcode executed
//  illegal      out  1   sticky: opcode 110 decoded
//  busy         out  1   1 in every state except IDLE, HALT, ILLEGAL
//  state_dbg    out  5   current state encoding
//  instr_count  out  COUNT_WIDTH  retired instructions
// BEHAVIOUR
//  Opcodes: 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 J, 101 ADDI, 110 illegal, 111 HALT.
//  Outputs decoded purely from state register; every control output is 0 unless listed for the state below.
//  Reset: state=IDLE, all controls 0, halted=illegal=0, instr_count=0; asserting reset mid-instruction aborts it
//   immediately (MemWrite/RegWrite/PCWrite drop same cycle, asynchronously).
//  IDLE: all 0; run=1 -> FETCH, else stay.
//  FETCH: MemRead, IorD=0 -> FETCH_WAIT.
//  FETCH_WAIT: MemRead, IRWrite, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite, PCSource=00 (PC+=2) -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next by opcode: 000 EXEC; 001/010 MEMADDR;
//   011 BRANCH; 100 JUMP; 101 ADDI_EX; 111 HALT; 110 ILLEGAL (ILLEGAL_TRAP=1) or FETCH-boundary (=0).
//  MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMREAD if opcode 001, MEMWRITE if 010.
//  MEMREAD: MemRead, IorD=1 -> MEMREAD_WAIT; MEMREAD_WAIT: MemRead, IorD=1 -> MEMWB.
//  MEMWB: RegWrite, MemtoReg=1, RegDst=0 -> boundary.
//  MEMWRITE: MemWrite, IorD=1 -> boundary.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB; RWB: RegDst=1, RegWrite, MemtoReg=0 -> boundary.
//  ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB; ADDI_WB: RegDst=0, RegWrite -> boundary.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 -> boundary.
//  JUMP: PCWrite, PCSource=10 -> boundary.
//  Boundary: instr_count+=1 (wraps) on leaving MEMWB/MEMWRITE/RWB/ADDI_WB/BRANCH/JUMP, and on DECODE of 110 when
//   ILLEGAL_TRAP=0; next = FETCH if run=1 else IDLE. run low mid-instruction never stalls it.
//  HALT/ILLEGAL: all controls 0, sticky flag=1 from entry cycle, exit only via reset; HALT does count as retired.
//  Latency (cycles incl. fetch): R 5, LW 7, SW 5, ADDI 5, BEQ 4, J 4, HALT 3 to parked.
//  PCWrite and PCWriteCond never both 1; MemRead and MemWrite never both 1.
// STRUCTURE
//  Shared include ControlDefs.vh: opcode localparams, 5-bit state encodings, ALUOp/ALUSrcB/PCSource codes.
//  Sub-module ctrl_word_decode: combinational state -> control-word table; top holds state reg, next-state, counter, flags.
// TESTING
//  1 Reset then run=1, opcode=000 held: FETCH,FETCH_WAIT,DECODE,EXEC,RWB; RWB has RegDst=1,RegWrite=1; instr_count=1.
//  2 LW (001): MemRead/IorD=1 in MEMREAD+MEMREAD_WAIT, MEMWB MemtoReg=1,RegWrite=1; 7 cycles/instr; SW: MemWrite 1 cycle.
//  3 BEQ (011): BRANCH has PCWriteCond=1,PCSource=01,ALUOp=01; J (100): JUMP PCWrite=1,PCSource=10; 4 cycles each.
//  4 Opcode 111: halted=1, busy=0, controls 0 forever with run=1; opcode 110 with TRAP=1: illegal=1, parked;
//    TRAP=0: illegal=1, FETCH follows, count+1.
//  5 Async reset asserted mid-MEMWRITE (between edges): MemWrite drops to 0 without clock, state_dbg=IDLE, count=0.
//  6 run dropped during EXEC: instruction completes (RWB), then IDLE; count with COUNT_WIDTH=4 wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, state encodings,
// DataPath select codes and the packed control word.
package multicycle_control_fsm_pkg;

  localparam logic [2:0] OP_RTYPE   = 3'b000;
  localparam logic [2:0] OP_LW      = 3'b001;
  localparam logic [2:0] OP_SW      = 3'b010;
  localparam logic [2:0] OP_BEQ     = 3'b011;
  localparam logic [2:0] OP_J       = 3'b100;
  localparam logic [2:0] OP_ADDI    = 3'b101;
  localparam logic [2:0] OP_ILLEGAL = 3'b110;
  localparam logic [2:0] OP_HALT    = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_SEXT   = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [4:0] {
    S_IDLE         = 5'd0,
    S_FETCH        = 5'd1,
    S_FETCH_WAIT   = 5'd2,
    S_DECODE       = 5'd3,
    S_MEMADDR      = 5'd4,
    S_MEMREAD      = 5'd5,
    S_MEMREAD_WAIT = 5'd6,
    S_MEMWB        = 5'd7,
    S_MEMWRITE     = 5'd8,
    S_EXEC         = 5'd9,
    S_RWB          = 5'd10,
    S_ADDI_EX      = 5'd11,
    S_ADDI_WB      = 5'd12,
    S_BRANCH       = 5'd13,
    S_JUMP         = 5'd14,
    S_HALT         = 5'd15,
    S_ILLEGAL      = 5'd16
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       alu_src_a;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_ZERO = ctrl_word_t'(16'h0000);

  // Idle and both parking states are the only non-busy states.
  function automatic logic is_parked(input state_t s);
    return (s == S_IDLE) || (s == S_HALT) || (s == S_ILLEGAL);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_ctrl_word_decode.sv
// Combinational state -> DataPath control-word table; every control is 0 unless
// the state explicitly drives it.
module multicycle_control_fsm_ctrl_word_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl,
  output logic       busy
);

  // Control word lookup for one state
  always_comb begin
    ctrl = CTRL_ZERO;
    busy = ~is_parked(state);
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
      end
      S_FETCH_WAIT: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD, S_MEMREAD_WAIT: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: begin
        ctrl = CTRL_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the 16-bit multi-cycle DataPath: sequencing, run gate,
// sticky halt/illegal flags and retired-instruction counter.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int COUNT_WIDTH  = 16,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [2:0]             opcode,
  output logic [1:0]             ALUOp,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             PCSource,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IorD,
  output logic                   RegWrite,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   ALUSrcA,
  output logic                   halted,
  output logic                   illegal,
  output logic                   busy,
  output logic [4:0]             state_dbg,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 state_nxt_s;
  ctrl_word_t             ctrl_r;
  ctrl_word_t             ctrl_nxt_s;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   halted_r;
  logic                   illegal_r;
  logic                   retire_s;
  logic                   illegal_set_s;
  logic [COUNT_WIDTH-1:0] instr_count_r;
  state_t                 boundary_s;

  // Outputs are decoded from the next state and registered, so they line up with
  // state_r and clear together with it on the asynchronous reset.
  multicycle_control_fsm_ctrl_word_decode u_decode (
    .state (state_nxt_s),
    .ctrl  (ctrl_nxt_s),
    .busy  (busy_nxt_s)
  );

  // Next-state, retire and illegal-detect logic
  always_comb begin
    boundary_s    = run ? S_FETCH : S_IDLE;
    state_nxt_s   = state_r;
    retire_s      = 1'b0;
    illegal_set_s = 1'b0;
    case (state_r)
      S_IDLE:         state_nxt_s = run ? S_FETCH : S_IDLE;
      S_FETCH:        state_nxt_s = S_FETCH_WAIT;
      S_FETCH_WAIT:   state_nxt_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_nxt_s = S_EXEC;
          OP_LW, OP_SW:  state_nxt_s = S_MEMADDR;
          OP_BEQ:        state_nxt_s = S_BRANCH;
          OP_J:          state_nxt_s = S_JUMP;
          OP_ADDI:       state_nxt_s = S_ADDI_EX;
          OP_HALT: begin
            state_nxt_s = S_HALT;
            retire_s    = 1'b1;
          end
          default: begin
            illegal_set_s = 1'b1;
            if (ILLEGAL_TRAP) begin
              state_nxt_s = S_ILLEGAL;
            end else begin
              state_nxt_s = boundary_s;
              retire_s    = 1'b1;
            end
          end
        endcase
      end
      // A store must be explicit; anything else takes the side-effect-free read path.
      S_MEMADDR:      state_nxt_s = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:      state_nxt_s = S_MEMREAD_WAIT;
      S_MEMREAD_WAIT: state_nxt_s = S_MEMWB;
      S_EXEC:         state_nxt_s = S_RWB;
      S_ADDI_EX:      state_nxt_s = S_ADDI_WB;
      S_MEMWB, S_MEMWRITE, S_RWB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_nxt_s = boundary_s;
        retire_s    = 1'b1;
      end
      S_HALT:         state_nxt_s = S_HALT;
      S_ILLEGAL:      state_nxt_s = S_ILLEGAL;
      default:        state_nxt_s = S_IDLE;
    endcase
  end

  // State, registered controls, sticky flags and retire counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      ctrl_r        <= CTRL_ZERO;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
      illegal_r     <= 1'b0;
      instr_count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      busy_r  <= busy_nxt_s;
      if (state_nxt_s == S_HALT) begin
        halted_r <= 1'b1;
      end
      if (illegal_set_s) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        instr_count_r <= instr_count_r + CNT_ONE;
      end
    end
  end

  assign ALUOp       = ctrl_r.alu_op;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign PCSource    = ctrl_r.pc_source;
  assign RegDst      = ctrl_r.reg_dst;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign IorD        = ctrl_r.i_or_d;
  assign RegWrite    = ctrl_r.reg_write;
  assign IRWrite     = ctrl_r.ir_write;
  assign PCWrite     = ctrl_r.pc_write;
  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign halted      = halted_r;
  assign illegal     = illegal_r;
  assign busy        = busy_r;
  assign state_dbg   = state_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: table of per-cycle vectors plus hand sequences for halt,
// illegal (trap and no-trap), asynchronous reset and counter wrap.
module tb_multicycle_control_fsm;

  localparam logic [4:0] S_IDLE = 5'd0,  S_FETCH = 5'd1,  S_FW = 5'd2,  S_DEC = 5'd3;
  localparam logic [4:0] S_MA = 5'd4,    S_MR = 5'd5,     S_MRW = 5'd6, S_MWB = 5'd7;
  localparam logic [4:0] S_MW = 5'd8,    S_EX = 5'd9,     S_RWB = 5'd10, S_AEX = 5'd11;
  localparam logic [4:0] S_AWB = 5'd12,  S_BR = 5'd13,    S_J = 5'd14,  S_HALT = 5'd15;
  localparam logic [4:0] S_ILL = 5'd16;

  // {ALUOp,ALUSrcB,PCSource,RegDst,MemtoReg,MemRead,MemWrite,IorD,RegWrite,IRWrite,PCWrite,PCWriteCond,ALUSrcA}
  localparam logic [15:0] C_ZERO = 16'h0000, C_FETCH = 16'h0080, C_FW = 16'h108C;
  localparam logic [15:0] C_DEC = 16'h3000, C_MA = 16'h2001, C_MR = 16'h00A0;
  localparam logic [15:0] C_MWB = 16'h0110, C_MW = 16'h0060, C_EX = 16'h8001;
  localparam logic [15:0] C_RWB = 16'h0210, C_AWB = 16'h0010, C_BR = 16'h4403;
  localparam logic [15:0] C_J = 16'h0804;

  logic clock, reset, run;
  logic [2:0] opcode;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic reg_dst, mem_to_reg, mem_read, mem_write, i_or_d, reg_write, ir_write;
  logic pc_write, pc_write_cond, alu_src_a, halted, illegal, busy;
  logic [4:0] state_dbg;
  logic [3:0] instr_count;

  logic [1:0] n_alu_op, n_alu_src_b, n_pc_source;
  logic n_reg_dst, n_mem_to_reg, n_mem_read, n_mem_write, n_i_or_d, n_reg_write, n_ir_write;
  logic n_pc_write, n_pc_write_cond, n_alu_src_a, n_halted, n_illegal, n_busy;
  logic [4:0] n_state_dbg;
  logic [3:0] n_instr_count;

  logic [15:0] cw;
  assign cw = {alu_op, alu_src_b, pc_source, reg_dst, mem_to_reg, mem_read, mem_write,
               i_or_d, reg_write, ir_write, pc_write, pc_write_cond, alu_src_a};

  multicycle_control_fsm #(.COUNT_WIDTH(4), .ILLEGAL_TRAP(1'b1)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .ALUOp(alu_op), .ALUSrcB(alu_src_b), .PCSource(pc_source),
    .RegDst(reg_dst), .MemtoReg(mem_to_reg), .MemRead(mem_read), .MemWrite(mem_write),
    .IorD(i_or_d), .RegWrite(reg_write), .IRWrite(ir_write), .PCWrite(pc_write),
    .PCWriteCond(pc_write_cond), .ALUSrcA(alu_src_a),
    .halted(halted), .illegal(illegal), .busy(busy),
    .state_dbg(state_dbg), .instr_count(instr_count)
  );

  multicycle_control_fsm #(.COUNT_WIDTH(4), .ILLEGAL_TRAP(1'b0)) dut_notrap (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .ALUOp(n_alu_op), .ALUSrcB(n_alu_src_b), .PCSource(n_pc_source),
    .RegDst(n_reg_dst), .MemtoReg(n_mem_to_reg), .MemRead(n_mem_read), .MemWrite(n_mem_write),
    .IorD(n_i_or_d), .RegWrite(n_reg_write), .IRWrite(n_ir_write), .PCWrite(n_pc_write),
    .PCWriteCond(n_pc_write_cond), .ALUSrcA(n_alu_src_a),
    .halted(n_halted), .illegal(n_illegal), .busy(n_busy),
    .state_dbg(n_state_dbg), .instr_count(n_instr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       run;
    logic [2:0] op;
    logic [4:0] st;
    logic [15:0] cw;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic add(input logic r, input logic [2:0] o, input logic [4:0] s,
                     input logic [15:0] c, input logic b, input logic [3:0] n);
    vec_t v;
    v.run = r; v.op = o; v.st = s; v.cw = c; v.busy = b; v.cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    opcode = 3'b000;

    // R-type, LW, SW, BEQ, J, ADDI, then R-type with run dropped during EXEC
    add(1'b1, 3'b000, S_FETCH, C_FETCH, 1'b1, 4'd0);
    add(1'b1, 3'b000, S_FW,    C_FW,    1'b1, 4'd0);
    add(1'b1, 3'b000, S_DEC,   C_DEC,   1'b1, 4'd0);
    add(1'b1, 3'b000, S_EX,    C_EX,    1'b1, 4'd0);
    add(1'b1, 3'b000, S_RWB,   C_RWB,   1'b1, 4'd0);
    add(1'b1, 3'b001, S_FETCH, C_FETCH, 1'b1, 4'd1);
    add(1'b1, 3'b001, S_FW,    C_FW,    1'b1, 4'd1);
    add(1'b1, 3'b001, S_DEC,   C_DEC,   1'b1, 4'd1);
    add(1'b1, 3'b001, S_MA,    C_MA,    1'b1, 4'd1);
    add(1'b1, 3'b001, S_MR,    C_MR,    1'b1, 4'd1);
    add(1'b1, 3'b001, S_MRW,   C_MR,    1'b1, 4'd1);
    add(1'b1, 3'b001, S_MWB,   C_MWB,   1'b1, 4'd1);
    add(1'b1, 3'b010, S_FETCH, C_FETCH, 1'b1, 4'd2);
    add(1'b1, 3'b010, S_FW,    C_FW,    1'b1, 4'd2);
    add(1'b1, 3'b010, S_DEC,   C_DEC,   1'b1, 4'd2);
    add(1'b1, 3'b010, S_MA,    C_MA,    1'b1, 4'd2);
    add(1'b1, 3'b010, S_MW,    C_MW,    1'b1, 4'd2);
    add(1'b1, 3'b011, S_FETCH, C_FETCH, 1'b1, 4'd3);
    add(1'b1, 3'b011, S_FW,    C_FW,    1'b1, 4'd3);
    add(1'b1, 3'b011, S_DEC,   C_DEC,   1'b1, 4'd3);
    add(1'b1, 3'b011, S_BR,    C_BR,    1'b1, 4'd3);
    add(1'b1, 3'b100, S_FETCH, C_FETCH, 1'b1, 4'd4);
    add(1'b1, 3'b100, S_FW,    C_FW,    1'b1, 4'd4);
    add(1'b1, 3'b100, S_DEC,   C_DEC,   1'b1, 4'd4);
    add(1'b1, 3'b100, S_J,     C_J,     1'b1, 4'd4);
    add(1'b1, 3'b101, S_FETCH, C_FETCH, 1'b1, 4'd5);
    add(1'b1, 3'b101, S_FW,    C_FW,    1'b1, 4'd5);
    add(1'b1, 3'b101, S_DEC,   C_DEC,   1'b1, 4'd5);
    add(1'b1, 3'b101, S_AEX,   C_MA,    1'b1, 4'd5);
    add(1'b1, 3'b101, S_AWB,   C_AWB,   1'b1, 4'd5);
    add(1'b1, 3'b000, S_FETCH, C_FETCH, 1'b1, 4'd6);
    add(1'b1, 3'b000, S_FW,    C_FW,    1'b1, 4'd6);
    add(1'b1, 3'b000, S_DEC,   C_DEC,   1'b1, 4'd6);
    add(1'b0, 3'b000, S_EX,    C_EX,    1'b1, 4'd6);
    add(1'b0, 3'b000, S_RWB,   C_RWB,   1'b1, 4'd6);
    add(1'b0, 3'b000, S_IDLE,  C_ZERO,  1'b0, 4'd7);
    add(1'b0, 3'b000, S_IDLE,  C_ZERO,  1'b0, 4'd7);

    do_reset();
    check("reset_state", {11'd0, state_dbg}, {11'd0, S_IDLE});
    check("reset_ctrl", cw, C_ZERO);
    check("reset_flags", {13'd0, halted, illegal, busy}, 16'h0000);
    check("reset_count", {12'd0, instr_count}, 16'h0000);

    for (int i = 0; i < vecs.size(); i++) begin
      run = vecs[i].run;
      opcode = vecs[i].op;
      tick();
      check($sformatf("v%0d_state", i), {11'd0, state_dbg}, {11'd0, vecs[i].st});
      check($sformatf("v%0d_ctrl", i), cw, vecs[i].cw);
      check($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].busy});
      check($sformatf("v%0d_count", i), {12'd0, instr_count}, {12'd0, vecs[i].cnt});
    end

    // Async reset in the middle of a store, from a nonzero count
    run = 1'b1;
    opcode = 3'b010;
    for (int i = 0; i < 5; i++) tick();
    check("sw_state", {11'd0, state_dbg}, {11'd0, S_MW});
    check("sw_memwrite", {15'd0, mem_write}, 16'h0001);
    check("sw_count", {12'd0, instr_count}, 16'h0007);
    #2;
    reset = 1'b1;
    #1;
    check("async_memwrite", {15'd0, mem_write}, 16'h0000);
    check("async_state", {11'd0, state_dbg}, {11'd0, S_IDLE});
    check("async_count", {12'd0, instr_count}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;

    // HALT: three cycles to parked, counts as retired, ignores run afterwards
    do_reset();
    run = 1'b1;
    opcode = 3'b111;
    for (int i = 0; i < 4; i++) tick();
    check("halt_state", {11'd0, state_dbg}, {11'd0, S_HALT});
    check("halt_flags", {13'd0, halted, illegal, busy}, 16'h0004);
    check("halt_count", {12'd0, instr_count}, 16'h0001);
    opcode = 3'b000;
    for (int i = 0; i < 3; i++) tick();
    check("halt_parked", {11'd0, state_dbg}, {11'd0, S_HALT});
    check("halt_ctrl", cw, C_ZERO);

    // Illegal opcode: trap instance parks, no-trap instance retires and refetches
    do_reset();
    run = 1'b1;
    opcode = 3'b110;
    for (int i = 0; i < 4; i++) tick();
    check("ill_trap_state", {11'd0, state_dbg}, {11'd0, S_ILL});
    check("ill_trap_flags", {13'd0, halted, illegal, busy}, 16'h0002);
    check("ill_trap_count", {12'd0, instr_count}, 16'h0000);
    check("ill_notrap_state", {11'd0, n_state_dbg}, {11'd0, S_FETCH});
    check("ill_notrap_flag", {15'd0, n_illegal}, 16'h0001);
    check("ill_notrap_count", {12'd0, n_instr_count}, 16'h0001);
    opcode = 3'b100;
    for (int i = 0; i < 4; i++) tick();
    check("ill_trap_parked", cw, C_ZERO);
    check("ill_notrap_next", {12'd0, n_instr_count}, 16'h0002);
    check("ill_notrap_sticky", {15'd0, n_illegal}, 16'h0001);

    // Counter wrap with 4-bit count: 15 jumps then one more
    do_reset();
    run = 1'b1;
    opcode = 3'b100;
    for (int i = 0; i < 1 + 4 * 15; i++) tick();
    check("wrap_15", {12'd0, instr_count}, 16'h000F);
    for (int i = 0; i < 4; i++) tick();
    check("wrap_0", {12'd0, instr_count}, 16'h0000);
    check("wrap_state", {11'd0, state_dbg}, {11'd0, S_FETCH});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
